phy_mdio_init_seq: RTL and testbench
====================================

// Module: phy_mdio_init_seq
// PURPOSE
//  Per-port KSZ9031 bring-up sequencer, one instance per net_udp_loop port, fed by the shared clk_50m.
//  - Drives the PHY hardware reset.
//  - Programs RGMII clock pad skew and autoneg through an MDIO master (req/ack).
//  - Then polls link status and speed, and publishes init_done/link_up/speed to the UDP datapath.
// PARAMETERS
//  PHY_ADDR        5'd0         MDIO PHY address used for every transaction
//  RST_HOLD_CYC    500_000      cycles phy_rst_n held low (10 ms @ 50 MHz)
//  RST_WAIT_CYC    50_000       cycles after phy_rst_n release before first MDIO access
//  POLL_CYC        500_000      cycles between link-poll rounds
//  ACK_TIMEOUT_CYC 4096         max cycles mdio_req may wait for mdio_ack
//  RGMII_CLK_SKEW  16'h03FF     value written to MMD2 reg 8 (TX_CLK[9:5], RX_CLK[4:0])
//  BMCR_VAL        16'h1340     value written to reg 0 (AN enable, AN restart, FDX, 1000)
// PORTS
//  clk_50m        in   1   sole clock
//  reset          in   1   asynchronous, active-high
//  restart        in   1   1-cycle pulse: abort and redo full bring-up
//  phy_rst_n      out  1   PHY hardware reset, low = reset
//  mdio_req       out  1   transaction request to MDIO master
//  mdio_wr        out  1   1 = write, 0 = read
//  mdio_phy_addr  out  5   = PHY_ADDR
//  mdio_reg_addr  out  5   clause-22 register address
//  mdio_wdata     out  16  write data
//  mdio_ack       in   1   1-cycle pulse: transaction complete
//  mdio_rdata     in   16  read data, valid in the mdio_ack cycle
//  init_done      out  1   configuration table fully written
//  link_up        out  1   last polled BMSR[2]
//  speed          out  2   00 = 10M, 01 = 100M, 10 = 1000M, 11 = unknown
//  timeout_err    out  1   sticky: an ack timeout has occurred
// BEHAVIOUR
//  Reset values: phy_rst_n 0, mdio_req 0, mdio_wr 0, addr/wdata 0, init_done 0, link_up 0, speed 00, timeout_err 0.
//  FSM: RST_HOLD -> RST_WAIT -> CFG_REQ <-> CFG_WAIT -> POLL_IDLE -> BMSR_REQ/WAIT -> STAT_REQ/WAIT -> POLL_IDLE.
//  - RST_HOLD: phy_rst_n = 0 for RST_HOLD_CYC cycles. RST_WAIT: phy_rst_n = 1 for RST_WAIT_CYC cycles.
//  - CFG: 5 writes in order: r13=0x0002, r14=0x0008, r13=0x4002, r14=RGMII_CLK_SKEW, r0=BMCR_VAL.
//  - init_done rises the cycle after the 5th ack and stays 1 until reset or restart.
//  - Poll round: read r1 (BMSR), then read r31 (PHY ctrl); POLL_IDLE waits POLL_CYC cycles (first round immediate).
//  - link_up and speed update together, in the cycle after the r31 ack; never from a partial round.
//  - Speed decode from r31: [6] -> 10, else [5] -> 01, else [4] -> 00, else 11.
//  - BMSR[2] = 0 -> link_up 0 and speed 00, whatever r31 returns.
//  Handshake:
//  - mdio_req rises in *_REQ; wr/addr/wdata are registered and stable while req is high.
//  - req falls the cycle after mdio_ack is sampled high. One outstanding transaction at most.
//  - Ack in the same cycle req rises is valid. Acks outside *_WAIT are ignored.
//  Timeout: ACK_TIMEOUT_CYC cycles in *_WAIT without ack ->
//  - req drops, timeout_err set, init_done, link_up and speed cleared, FSM -> RST_HOLD.
//  restart pulse (any state) ->
//  - next cycle: RST_HOLD, phy_rst_n 0, req 0, init_done, link_up and speed cleared; timeout_err kept.
//  - A late ack from the aborted frame is ignored.
//  - restart while already in RST_HOLD: hold counter reloads.
//  Counters: a single down-counter, width clog2 of the largest cycle parameter; loaded on state entry, no wrap.
// CONFIGURATION
//  PHY_LINK_POLL_EN defined:
//  - poll states are built; link_up and speed follow the PHY.
//  PHY_LINK_POLL_EN undefined:
//  - FSM parks in a DONE state after CFG; no MDIO reads are issued.
//  - link_up = init_done; speed = 10 while init_done, else 00.
// TESTING
//  Stub MDIO master: ack 40 cycles after req; RST_HOLD_CYC=20, RST_WAIT_CYC=10, POLL_CYC=100.
//  1. Reset release -> phy_rst_n 0 for 20 cycles, then 1.
//     10 cycles later, 5 writes (r13=0002, r14=0008, r13=4002, r14=03FF, r0=1340); init_done=1.
//  2. BMSR=0x796D, r31=0x0040 -> link_up 1, speed 10.
//     Change r31 to 0x0020 -> speed 01 after the next round, 100 cycles later.
//  3. BMSR=0x7969 (link bit 0) with r31=0x0040 -> link_up 0, speed 00.
//  4. Stub withholds ack on write 3 -> after 4096 cycles timeout_err=1, phy_rst_n 0, sequence restarts.
//  5. restart pulse during r14 write, then late ack -> ack ignored, RST_HOLD re-entered, full table rewritten.
//  6. Build without PHY_LINK_POLL_EN -> no reads issued; link_up=1 and speed 10 once init_done=1.

Source files
------------

// File: rtl/phy_mdio_init_seq_if.sv
// MDIO request/acknowledge bus between the PHY bring-up sequencer and its MDIO master.
// master = sequencer side, slave = MDIO engine side.
interface phy_mdio_init_seq_if;
    logic        mdio_req;
    logic        mdio_wr;
    logic [4:0]  mdio_phy_addr;
    logic [4:0]  mdio_reg_addr;
    logic [15:0] mdio_wdata;
    logic        mdio_ack;
    logic [15:0] mdio_rdata;

    modport master (
        output mdio_req, mdio_wr, mdio_phy_addr, mdio_reg_addr, mdio_wdata,
        input  mdio_ack, mdio_rdata
    );

    modport slave (
        input  mdio_req, mdio_wr, mdio_phy_addr, mdio_reg_addr, mdio_wdata,
        output mdio_ack, mdio_rdata
    );
endinterface

// File: rtl/phy_mdio_init_seq.sv
// KSZ9031 bring-up sequencer: PHY hardware reset, MDIO configuration writes, link/speed polling.
// Macro PHY_LINK_POLL_EN builds the poll loop; without it the FSM parks in DONE after configuration.
module phy_mdio_init_seq #(
    parameter logic [4:0]  PHY_ADDR        = 5'd0,
    parameter int          RST_HOLD_CYC    = 500_000,
    parameter int          RST_WAIT_CYC    = 50_000,
    parameter int          POLL_CYC        = 500_000,
    parameter int          ACK_TIMEOUT_CYC = 4096,
    parameter logic [15:0] RGMII_CLK_SKEW  = 16'h03FF,
    parameter logic [15:0] BMCR_VAL        = 16'h1340
) (
    input  logic                       clk_50m,
    input  logic                       reset,
    input  logic                       restart,
    output logic                       phy_rst_n,
    phy_mdio_init_seq_if.master        bus,
    output logic                       init_done,
    output logic                       link_up,
    output logic [1:0]                 speed,
    output logic                       timeout_err
);

    localparam int MAX_AB  = (RST_HOLD_CYC > RST_WAIT_CYC) ? RST_HOLD_CYC : RST_WAIT_CYC;
    localparam int MAX_CD  = (POLL_CYC > ACK_TIMEOUT_CYC) ? POLL_CYC : ACK_TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [3:0] {
        RST_HOLD, RST_WAIT, CFG_REQ, CFG_WAIT, POLL_IDLE,
        BMSR_REQ, BMSR_WAIT, STAT_REQ, STAT_WAIT, DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    cfg_idx;
    logic          is_wait;

    // {reg_addr, wdata}: MMD2 reg 8 is reached indirectly through r13/r14
    function automatic logic [20:0] cfg_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    return {5'd13, 16'h0002};
            3'd1:    return {5'd14, 16'h0008};
            3'd2:    return {5'd13, 16'h4002};
            3'd3:    return {5'd14, RGMII_CLK_SKEW};
            default: return {5'd0,  BMCR_VAL};
        endcase
    endfunction

`ifdef PHY_LINK_POLL_EN
    logic bmsr_link;

    function automatic logic [1:0] decode_speed(input logic [15:0] r);
        return r[6] ? 2'b10 : (r[5] ? 2'b01 : (r[4] ? 2'b00 : 2'b11));
    endfunction
`endif

    assign is_wait = (state == CFG_WAIT) || (state == BMSR_WAIT) || (state == STAT_WAIT);

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state             <= RST_HOLD;
            cnt               <= CW'(RST_HOLD_CYC - 1);
            cfg_idx           <= '0;
            phy_rst_n         <= 1'b0;
            bus.mdio_req      <= 1'b0;
            bus.mdio_wr       <= 1'b0;
            bus.mdio_phy_addr <= '0;
            bus.mdio_reg_addr <= '0;
            bus.mdio_wdata    <= '0;
            init_done         <= 1'b0;
            link_up           <= 1'b0;
            speed             <= 2'b00;
            timeout_err       <= 1'b0;
`ifdef PHY_LINK_POLL_EN
            bmsr_link         <= 1'b0;
`endif
        end else if (restart || (is_wait && !bus.mdio_ack && cnt == '0)) begin
            // both abort paths re-run the full bring-up; only a timeout is recorded
            state        <= RST_HOLD;
            cnt          <= CW'(RST_HOLD_CYC - 1);
            cfg_idx      <= '0;
            phy_rst_n    <= 1'b0;
            bus.mdio_req <= 1'b0;
            init_done    <= 1'b0;
            link_up      <= 1'b0;
            speed        <= 2'b00;
            if (!restart)
                timeout_err <= 1'b1;
        end else begin
            case (state)
                RST_HOLD: begin
                    if (cnt == '0) begin
                        state     <= RST_WAIT;
                        cnt       <= CW'(RST_WAIT_CYC - 1);
                        phy_rst_n <= 1'b1;
                    end else
                        cnt <= cnt - 1'b1;
                end
                RST_WAIT: begin
                    if (cnt == '0)
                        state <= CFG_REQ;
                    else
                        cnt <= cnt - 1'b1;
                end
                CFG_REQ: begin
                    bus.mdio_req      <= 1'b1;
                    bus.mdio_wr       <= 1'b1;
                    bus.mdio_phy_addr <= PHY_ADDR;
                    {bus.mdio_reg_addr, bus.mdio_wdata} <= cfg_entry(cfg_idx);
                    cnt               <= CW'(ACK_TIMEOUT_CYC - 1);
                    state             <= CFG_WAIT;
                end
                CFG_WAIT: begin
                    if (bus.mdio_ack) begin
                        bus.mdio_req <= 1'b0;
                        if (cfg_idx == 3'd4) begin
                            init_done <= 1'b1;
`ifdef PHY_LINK_POLL_EN
                            state     <= POLL_IDLE;
                            cnt       <= '0;
`else
                            state     <= DONE;
                            link_up   <= 1'b1;
                            speed     <= 2'b10;
`endif
                        end else begin
                            cfg_idx <= cfg_idx + 3'd1;
                            state   <= CFG_REQ;
                        end
                    end else
                        cnt <= cnt - 1'b1;
                end
`ifdef PHY_LINK_POLL_EN
                POLL_IDLE: begin
                    if (cnt == '0)
                        state <= BMSR_REQ;
                    else
                        cnt <= cnt - 1'b1;
                end
                BMSR_REQ, STAT_REQ: begin
                    bus.mdio_req      <= 1'b1;
                    bus.mdio_wr       <= 1'b0;
                    bus.mdio_phy_addr <= PHY_ADDR;
                    bus.mdio_reg_addr <= (state == BMSR_REQ) ? 5'd1 : 5'd31;
                    bus.mdio_wdata    <= '0;
                    cnt               <= CW'(ACK_TIMEOUT_CYC - 1);
                    state             <= (state == BMSR_REQ) ? BMSR_WAIT : STAT_WAIT;
                end
                BMSR_WAIT: begin
                    if (bus.mdio_ack) begin
                        bus.mdio_req <= 1'b0;
                        bmsr_link    <= bus.mdio_rdata[2];
                        state        <= STAT_REQ;
                    end else
                        cnt <= cnt - 1'b1;
                end
                STAT_WAIT: begin
                    if (bus.mdio_ack) begin
                        bus.mdio_req <= 1'b0;
                        link_up      <= bmsr_link;
                        speed        <= bmsr_link ? decode_speed(bus.mdio_rdata) : 2'b00;
                        cnt          <= CW'(POLL_CYC - 1);
                        state        <= POLL_IDLE;
                    end else
                        cnt <= cnt - 1'b1;
                end
`endif
                DONE: ;
                default: state <= RST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_mdio_init_seq.sv
// Directed bench for phy_mdio_init_seq with a stub MDIO master acking 40 cycles after each request.
// Poll-loop checks are built only when PHY_LINK_POLL_EN is defined.
module tb_phy_mdio_init_seq;
    logic       clk_50m = 1'b0;
    logic       reset;
    logic       restart;
    logic       phy_rst_n;
    logic       init_done;
    logic       link_up;
    logic [1:0] speed;
    logic       timeout_err;

    phy_mdio_init_seq_if bus();

    phy_mdio_init_seq #(
        .RST_HOLD_CYC    (20),
        .RST_WAIT_CYC    (10),
        .POLL_CYC        (100),
        .ACK_TIMEOUT_CYC (4096)
    ) dut (
        .clk_50m     (clk_50m),
        .reset       (reset),
        .restart     (restart),
        .phy_rst_n   (phy_rst_n),
        .bus         (bus),
        .init_done   (init_done),
        .link_up     (link_up),
        .speed       (speed),
        .timeout_err (timeout_err)
    );

    always #10 clk_50m = ~clk_50m;

    localparam logic [21:0] EXP_CFG [5] = '{
        {1'b1, 5'd13, 16'h0002},
        {1'b1, 5'd14, 16'h0008},
        {1'b1, 5'd13, 16'h4002},
        {1'b1, 5'd14, 16'h03FF},
        {1'b1, 5'd0,  16'h1340}
    };

    int          checks = 0;
    int          errors = 0;
    int          withhold_idx = -1;
    logic [15:0] bmsr_val = 16'h796D;
    logic [15:0] r31_val  = 16'h0040;
    logic [21:0] log_q[$];
    bit          stub_busy = 1'b0;
    bit          stub_hold = 1'b0;
    int          stub_cnt = 0;
    logic [4:0]  stub_reg = '0;

    // stub MDIO master: logs {wr, reg, wdata}, acks 40 cycles later even if req was withdrawn
    initial begin
        bus.mdio_ack   = 1'b0;
        bus.mdio_rdata = '0;
        forever begin
            @(negedge clk_50m);
            bus.mdio_ack = 1'b0;
            if (!stub_busy) begin
                if (bus.mdio_req === 1'b1) begin
                    stub_hold = (withhold_idx == log_q.size());
                    log_q.push_back({bus.mdio_wr, bus.mdio_reg_addr, bus.mdio_wdata});
                    stub_reg  = bus.mdio_reg_addr;
                    stub_busy = 1'b1;
                    stub_cnt  = 0;
                end
            end else if (stub_hold) begin
                if (bus.mdio_req !== 1'b1) stub_busy = 1'b0;
            end else begin
                stub_cnt++;
                if (stub_cnt == 40) begin
                    bus.mdio_ack   = 1'b1;
                    bus.mdio_rdata = (stub_reg == 5'd1) ? bmsr_val :
                                     (stub_reg == 5'd31) ? r31_val : 16'h0000;
                    stub_busy      = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return phy_rst_n === 1'b1;
            1: return init_done === 1'b1;
            2: return bus.mdio_req === 1'b1;
            3: return timeout_err === 1'b1;
            4: return bus.mdio_req === 1'b1 && bus.mdio_wdata === 16'h4002;
            5: return bus.mdio_req === 1'b1 && bus.mdio_wdata === 16'h03FF;
            6: return link_up === 1'b1;
            7: return speed === 2'b01;
            8: return link_up === 1'b0;
            9: return !stub_busy && bus.mdio_req === 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    // counts posedges until cond(sel) holds, sampling 1 ns after each edge
    task automatic wait_for(input int sel, input int maxc, output int n);
        bit hit;
        n   = 0;
        hit = cond(sel);
        while (!hit && n < maxc) begin
            @(posedge clk_50m);
            #1;
            n++;
            hit = cond(sel);
        end
        checks++;
        assert (hit === 1'b1) else begin
            errors++;
            $error("FAIL wait_%0d: condition not reached after %0d cycles, required within %0d", sel, n, maxc);
        end
    endtask

    task automatic check_table(input string pfx);
        check({pfx, "_count"}, log_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s_wr%0d", pfx, i), (i < log_q.size()) ? log_q[i] : 22'h3FFFFF, EXP_CFG[i]);
    endtask

    task automatic pulse_restart_and_check(input string pfx);
        @(negedge clk_50m);
        restart = 1'b1;
        @(posedge clk_50m);
        #1;
        check({pfx, "_rst_n"}, phy_rst_n, 0);
        check({pfx, "_req"},   bus.mdio_req, 0);
        check({pfx, "_done"},  init_done, 0);
        check({pfx, "_link"},  link_up, 0);
        check({pfx, "_speed"}, speed, 0);
        @(negedge clk_50m);
        restart = 1'b0;
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        restart = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1;
        check("rst_phy_rst_n", phy_rst_n, 0);
        check("rst_req",       bus.mdio_req, 0);
        check("rst_wr",        bus.mdio_wr, 0);
        check("rst_reg_addr",  bus.mdio_reg_addr, 0);
        check("rst_wdata",     bus.mdio_wdata, 0);
        check("rst_init_done", init_done, 0);
        check("rst_link_up",   link_up, 0);
        check("rst_speed",     speed, 0);
        check("rst_timeout",   timeout_err, 0);

        // 1: hold 20 cycles, wait 10 cycles + issue cycle, then the 5 configuration writes
        @(negedge clk_50m);
        reset = 1'b0;
        wait_for(0, 100, n);
        check("hold_len", n, 20);
        wait_for(2, 100, n);
        check("wait_len", n, 11);
        check("first_wr", bus.mdio_wr, 1);
        wait_for(1, 1000, n);
        check_table("cfg");
        check("cfg_timeout", timeout_err, 0);

`ifdef PHY_LINK_POLL_EN
        // 2/3: link and speed follow the polled registers
        wait_for(6, 300, n);
        check("poll_speed_1000", speed, 2'b10);
        check("poll_rd_bmsr", (log_q.size() > 5) ? log_q[5][21:16] : 6'h3F, {1'b0, 5'd1});
        check("poll_rd_r31",  (log_q.size() > 6) ? log_q[6][21:16] : 6'h3F, {1'b0, 5'd31});
        r31_val = 16'h0020;
        wait_for(7, 400, n);
        check("poll_link_100", link_up, 1);
        bmsr_val = 16'h7969;
        wait_for(8, 400, n);
        check("poll_nolink_speed", speed, 2'b00);
        bmsr_val = 16'h796D;
        r31_val  = 16'h0040;
        wait_for(9, 200, n);
`else
        // 6: no poll loop, link/speed track init_done and no reads are issued
        check("nopoll_link", link_up, 1);
        check("nopoll_speed", speed, 2'b10);
        repeat (300) @(posedge clk_50m);
        #1;
        check("nopoll_txn_count", log_q.size(), 5);
        check("nopoll_req_idle", bus.mdio_req, 0);
        check("nopoll_link_held", link_up, 1);
`endif

        // 4: third write never acknowledged -> timeout after 4096 cycles
        log_q.delete();
        withhold_idx = 2;
        pulse_restart_and_check("rs1");
        wait_for(4, 1000, n);
        wait_for(3, 5000, n);
        check("to_len", n, 4096);
        check("to_rst_n", phy_rst_n, 0);
        check("to_req", bus.mdio_req, 0);
        check("to_done", init_done, 0);
        check("to_link", link_up, 0);
        check("to_txn_count", log_q.size(), 3);
        withhold_idx = -1;
        log_q.delete();

        // 5: restart mid r14 write, second restart reloads the hold counter, late ack ignored
        wait_for(5, 1000, n);
        repeat (25) @(posedge clk_50m);
        #1;
        pulse_restart_and_check("rs2");
        repeat (4) @(posedge clk_50m);
        @(negedge clk_50m);
        restart = 1'b1;
        @(posedge clk_50m);
        #1;
        log_q.delete();
        @(negedge clk_50m);
        restart = 1'b0;
        wait_for(0, 100, n);
        check("reload_hold_len", n, 20);
        wait_for(1, 1000, n);
        check_table("rewr");
        check("sticky_timeout", timeout_err, 1);
`ifndef PHY_LINK_POLL_EN
        check("rewr_link", link_up, 1);
        check("rewr_speed", speed, 2'b10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
